wb_port_arbiter: RTL and testbench

- Owns the single register-file write port and shares it between two writers: the core writeback path and a long-latency unit (multi-cycle mul/div).
- The core writeback path is the result of the writeback mux: write enable, rd, data.
- The core has priority. Long-latency results are held in a one-entry buffer until a free write slot appears.
- A starvation counter stalls the core for one cycle so that a waiting result can retire.

---
 rtl/wb_port_arbiter_if.sv | 53 +++++
 rtl/wb_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the signals around the register-file write port arbiter:
// the core writeback path, the long-latency unit result path, the single
// register-file write port, and a debug view of the arbiter state.
//
// Handshake: the long-latency unit presents lu_valid/lu_rd/lu_wdata and a
// result is accepted only in a cycle where lu_valid & lu_ready are both 1.
// When lu_valid=1 and lu_ready=0, the unit must hold the result stable.
// The core path has no handshake. core_stall=1 means the core's write that
// cycle did not happen and must be presented again the next cycle.
interface wb_port_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    // Core writeback path.
    logic          core_we;
    logic [AW-1:0] core_rd;
    logic [DW-1:0] core_wdata;
    logic          core_stall;

    // Long-latency unit result path.
    logic          lu_valid;
    logic [AW-1:0] lu_rd;
    logic [DW-1:0] lu_wdata;
    logic          lu_ready;
    logic          lu_pending;
    logic [AW-1:0] lu_pending_rd;

    // Register-file write port.
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    // Arbiter state for debug and checkers: 0=EMPTY, 1=HELD, 2=FORCE.
    logic [1:0]    dbg_state;

    // Arbiter side.
    modport slave (
        input  core_we, core_rd, core_wdata,
        input  lu_valid, lu_rd, lu_wdata,
        output core_stall, lu_ready, lu_pending, lu_pending_rd,
        output rf_we, rf_waddr, rf_wdata,
        output dbg_state
    );

    // Writers and register-file side.
    modport master (
        output core_we, core_rd, core_wdata,
        output lu_valid, lu_rd, lu_wdata,
        input  core_stall, lu_ready, lu_pending, lu_pending_rd,
        input  rf_we, rf_waddr, rf_wdata,
        input  dbg_state
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter.
// Shares one register-file write port between the core writeback path and
// a long-latency (mul/div) unit. The core has priority. A long-latency
// result waits in a one-entry buffer until the core leaves a free slot.
// If the core keeps the port busy for MAX_WAIT consecutive cycles, the core
// is stalled for one cycle so that the buffered result can retire.
// All outputs are combinational from state and inputs, so a granted write
// lands in the same cycle.
module wb_port_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int MAX_WAIT = 4    // legal range 1..15, fits wait_cnt
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HELD  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] buf_rd_q, buf_rd_d;
    logic [DW-1:0] buf_data_q, buf_data_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;

    logic          core_wr;
    logic          rf_we_c;
    logic [AW-1:0] rf_waddr_c;
    logic [DW-1:0] rf_wdata_c;
    logic          core_stall_c;
    logic          lu_ready_c;
    logic          lu_keep;

    // A write to x0 is architecturally a no-op, so it does not claim the port.
    assign core_wr = bus.core_we && (bus.core_rd != '0);

    // State, buffer and starvation counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state and write-port selection.
    always_comb begin
        state_d      = state_q;
        buf_rd_d     = buf_rd_q;
        buf_data_d   = buf_data_q;
        wait_cnt_d   = wait_cnt_q;
        rf_we_c      = 1'b0;
        rf_waddr_c   = '0;
        rf_wdata_c   = '0;
        core_stall_c = 1'b0;
        lu_ready_c   = 1'b0;
        lu_keep      = 1'b0;

        unique case (state_q)
            ST_EMPTY: begin
                lu_ready_c = 1'b1;
                if (core_wr) begin
                    rf_we_c    = 1'b1;
                    rf_waddr_c = bus.core_rd;
                    rf_wdata_c = bus.core_wdata;
                end
                // Never bypassed to the port: the result sits in HELD first.
                // A result for x0 is accepted and simply dropped.
                lu_keep = bus.lu_valid && (bus.lu_rd != '0);
                if (lu_keep) begin
                    state_d    = ST_HELD;
                    buf_rd_d   = bus.lu_rd;
                    buf_data_d = bus.lu_wdata;
                    wait_cnt_d = '0;
                end
            end

            ST_HELD: begin
                if (!core_wr) begin
                    // Free slot: retire the buffer, which can refill at once.
                    rf_we_c    = 1'b1;
                    rf_waddr_c = buf_rd_q;
                    rf_wdata_c = buf_data_q;
                    lu_ready_c = 1'b1;
                    state_d    = ST_EMPTY;
                    wait_cnt_d = '0;
                    lu_keep    = bus.lu_valid && (bus.lu_rd != '0);
                    if (lu_keep) begin
                        state_d    = ST_HELD;
                        buf_rd_d   = bus.lu_rd;
                        buf_data_d = bus.lu_wdata;
                    end
                end else begin
                    rf_we_c    = 1'b1;
                    rf_waddr_c = bus.core_rd;
                    rf_wdata_c = bus.core_wdata;
                    if (bus.core_rd == buf_rd_q) begin
                        // Younger core write to the same register makes the
                        // buffered value stale; drop it rather than retire it.
                        state_d    = ST_EMPTY;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                        if (wait_cnt_q == 4'(MAX_WAIT - 1)) begin
                            state_d = ST_FORCE;
                        end
                    end
                end
            end

            ST_FORCE: begin
                // Core is held off for one cycle and replays its write next.
                core_stall_c = 1'b1;
                rf_we_c      = 1'b1;
                rf_waddr_c   = buf_rd_q;
                rf_wdata_c   = buf_data_q;
                wait_cnt_d   = '0;
                state_d      = ST_EMPTY;
                // lu_ready is low here, so nothing can be accepted this cycle.
                lu_keep = bus.lu_valid && lu_ready_c && (bus.lu_rd != '0);
                if (lu_keep) begin
                    state_d    = ST_HELD;
                    buf_rd_d   = bus.lu_rd;
                    buf_data_d = bus.lu_wdata;
                end
            end

            default: begin
                state_d    = ST_EMPTY;
                wait_cnt_d = '0;
            end
        endcase

        // While in reset nothing is written, stalled or offered.
        if (rst) begin
            rf_we_c      = 1'b0;
            rf_waddr_c   = '0;
            rf_wdata_c   = '0;
            core_stall_c = 1'b0;
            lu_ready_c   = 1'b0;
        end
    end

    assign bus.rf_we         = rf_we_c;
    assign bus.rf_waddr      = rf_waddr_c;
    assign bus.rf_wdata      = rf_wdata_c;
    assign bus.core_stall    = core_stall_c;
    assign bus.lu_ready      = lu_ready_c;
    assign bus.lu_pending    = (state_q != ST_EMPTY) && !rst;
    assign bus.lu_pending_rd = buf_rd_q;
    assign bus.dbg_state     = state_q;

    // The stall lasts exactly one cycle at a time.
    a_stall_single: assert property (@(posedge clk) disable iff (rst)
        bus.core_stall |=> !bus.core_stall);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios with
// register-file writes checked against an expected-write queue.
module tb_wb_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_HELD  = 2'd1;
    localparam logic [1:0] S_FORCE = 2'd2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [AW+DW-1:0] exp_q[$];

    wb_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    wb_port_arbiter #(.DW(DW), .AW(AW), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every register-file write must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.rf_we !== 1'b0) begin
            logic [AW+DW-1:0] exp;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rf_write: got we=%b addr=%0d data=%h, required no write",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata);
            end else begin
                exp = exp_q.pop_front();
                if (bus.rf_we !== 1'b1 || {bus.rf_waddr, bus.rf_wdata} !== exp) begin
                    bad++;
                    $display("FAIL rf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.rf_waddr, bus.rf_wdata, exp[AW+DW-1:DW], exp[DW-1:0]);
                end
            end
        end
    end

    // Driver tasks.
    task automatic drive(input logic cwe, input logic [AW-1:0] crd, input logic [DW-1:0] cdat,
                         input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat);
        bus.core_we    = cwe;
        bus.core_rd    = crd;
        bus.core_wdata = cdat;
        bus.lu_valid   = lv;
        bus.lu_rd      = lrd;
        bus.lu_wdata   = ldat;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic test_drained(input string name);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drained: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 5, 32'h5555_0000, 1, 7, 32'h7777_0000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({bus.rf_we, bus.lu_ready, bus.core_stall, bus.lu_pending} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_outputs: got we/ready/stall/pend=%b, required 0000",
                         {bus.rf_we, bus.lu_ready, bus.core_stall, bus.lu_pending});
            end
            next_cycle();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if (bus.dbg_state !== S_EMPTY || bus.lu_ready !== 1'b1 || bus.lu_pending !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got state=%0d ready=%b pend=%b, required 0 1 0",
                     bus.dbg_state, bus.lu_ready, bus.lu_pending);
        end
        next_cycle();
    endtask

    task automatic test_idle_retire();
        drive(0, 0, 0, 1, 7, 32'hDEAD_BEEF);
        @(negedge clk);
        total++;
        if (bus.lu_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_accept: got lu_ready=%b, required 1", bus.lu_ready);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        expect_write(7, 32'hDEAD_BEEF);
        @(negedge clk);
        total++;
        if (bus.lu_pending !== 1'b1 || bus.lu_pending_rd !== 5'd7) begin
            bad++;
            $display("FAIL idle_pending: got pend=%b rd=%0d, required 1 7",
                     bus.lu_pending, bus.lu_pending_rd);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (bus.lu_pending !== 1'b0) begin
            bad++;
            $display("FAIL idle_retired: got pend=%b, required 0", bus.lu_pending);
        end
        next_cycle();
        test_drained("idle");
    endtask

    task automatic test_starvation();
        drive(0, 0, 0, 1, 3, 32'h0000_0033);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] d;
            d = 32'h5500 + DW'(i);
            drive(1, 5, d, 0, 0, 0);
            expect_write(5, d);
            @(negedge clk);
            total++;
            if (bus.core_stall !== 1'b0 || bus.dbg_state !== S_HELD) begin
                bad++;
                $display("FAIL starve_denied%0d: got stall=%b state=%0d, required 0 1",
                         i, bus.core_stall, bus.dbg_state);
            end
            next_cycle();
        end
        drive(1, 5, 32'h5560, 0, 0, 0);
        expect_write(3, 32'h0000_0033);
        @(negedge clk);
        total++;
        if (bus.core_stall !== 1'b1 || bus.dbg_state !== S_FORCE) begin
            bad++;
            $display("FAIL starve_force: got stall=%b state=%0d, required 1 2",
                     bus.core_stall, bus.dbg_state);
        end
        next_cycle();
        expect_write(5, 32'h5560);
        @(negedge clk);
        total++;
        if (bus.core_stall !== 1'b0 || bus.lu_pending !== 1'b0) begin
            bad++;
            $display("FAIL starve_replay: got stall=%b pend=%b, required 0 0",
                     bus.core_stall, bus.lu_pending);
        end
        next_cycle();
        test_drained("starve");
    endtask

    task automatic test_waw();
        drive(0, 0, 0, 1, 9, 32'h0000_0011);
        next_cycle();
        drive(1, 9, 32'h0000_0022, 0, 0, 0);
        expect_write(9, 32'h0000_0022);
        @(negedge clk);
        total++;
        if (bus.lu_pending !== 1'b1 || bus.core_stall !== 1'b0) begin
            bad++;
            $display("FAIL waw_held: got pend=%b stall=%b, required 1 0",
                     bus.lu_pending, bus.core_stall);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if (bus.lu_pending !== 1'b0 || bus.dbg_state !== S_EMPTY) begin
            bad++;
            $display("FAIL waw_discard: got pend=%b state=%0d, required 0 0",
                     bus.lu_pending, bus.dbg_state);
        end
        next_cycle();
        next_cycle();
        test_drained("waw");
    endtask

    task automatic test_x0();
        drive(0, 0, 0, 1, 0, 32'h0000_0BAD);
        @(negedge clk);
        total++;
        if (bus.lu_ready !== 1'b1) begin
            bad++;
            $display("FAIL x0_lu_accept: got lu_ready=%b, required 1", bus.lu_ready);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if (bus.lu_pending !== 1'b0 || bus.dbg_state !== S_EMPTY) begin
            bad++;
            $display("FAIL x0_lu_drop: got pend=%b state=%0d, required 0 0",
                     bus.lu_pending, bus.dbg_state);
        end
        next_cycle();
        drive(0, 0, 0, 1, 12, 32'h0000_000C);
        next_cycle();
        drive(1, 0, 32'h0000_00FF, 0, 0, 0);
        expect_write(12, 32'h0000_000C);
        @(negedge clk);
        total++;
        if (bus.core_stall !== 1'b0 || bus.lu_ready !== 1'b1) begin
            bad++;
            $display("FAIL x0_core_grant: got stall=%b ready=%b, required 0 1",
                     bus.core_stall, bus.lu_ready);
        end
        next_cycle();
        test_drained("x0");
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 0, 1, 4, 32'h0000_0044);
        next_cycle();
        drive(0, 0, 0, 1, 6, 32'h0000_0066);
        expect_write(4, 32'h0000_0044);
        @(negedge clk);
        total++;
        if (bus.lu_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready: got lu_ready=%b, required 1", bus.lu_ready);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        expect_write(6, 32'h0000_0066);
        @(negedge clk);
        total++;
        if (bus.dbg_state !== S_HELD || bus.lu_pending_rd !== 5'd6) begin
            bad++;
            $display("FAIL b2b_refill: got state=%0d rd=%0d, required 1 6",
                     bus.dbg_state, bus.lu_pending_rd);
        end
        next_cycle();
        test_drained("b2b");
    endtask

    // Randomised core traffic on registers other than the buffered one;
    // the buffered result must retire at the first idle slot or by force.
    task automatic test_random_core();
        for (int n = 0; n < 20; n++) begin
            int busy;
            logic [DW-1:0] ld;
            busy = $urandom_range(0, 6);
            ld   = $urandom();
            drive(0, 0, 0, 1, 20, ld);
            next_cycle();
            for (int c = 0; c < busy && c < 4; c++) begin
                logic [DW-1:0] cd;
                cd = $urandom();
                drive(1, AW'($urandom_range(1, 19)), cd, 0, 0, 0);
                expect_write(bus.core_rd, cd);
                next_cycle();
            end
            drive(0, 0, 0, 0, 0, 0);
            if (busy >= 4) begin
                // Fourth denial forces a stalled retire; the core stays idle.
                expect_write(20, ld);
                @(negedge clk);
                total++;
                if (bus.core_stall !== 1'b1) begin
                    bad++;
                    $display("FAIL rand_force%0d: got stall=%b, required 1", n, bus.core_stall);
                end
            end else begin
                expect_write(20, ld);
                @(negedge clk);
            end
            next_cycle();
        end
        test_drained("random");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_idle_retire();
        test_starvation();
        test_waw();
        test_x0();
        test_back_to_back();
        test_random_core();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
